// File: rtl/chip_bus_pkg.sv
// Shared types and defaults for the chip-RAM bus arbiter.
package chip_bus_pkg;

    localparam int DEF_NREQ        = 4;
    localparam int DEF_SLOT_LEN    = 2;
    localparam int DEF_CPU_WAIT    = 2;
    localparam int DEF_MAX_DMA_RUN = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RFSH,
        ST_DMA,
        ST_CPU_WAIT,
        ST_CPU_ACK
    } arb_state_e;

    // Width of a counter that must hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/chip_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester strictly after ptr wins.
module rr_picker #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         sel,
    output logic                    any
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] idx;

    always_comb begin
        sel = '0;
        any = 1'b0;
        idx = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (!any && req[idx]) begin
                sel[idx] = 1'b1;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chip_bus_arbiter.sv
// Chip-RAM bus arbiter: refresh, CPU and round-robin DMA in fixed slots,
// with a starvation limit that forces the CPU in after a run of DMA grants.
module chip_bus_arbiter
    import chip_bus_pkg::*;
#(
    parameter int NREQ        = DEF_NREQ,
    parameter int SLOT_LEN    = DEF_SLOT_LEN,
    parameter int CPU_WAIT    = DEF_CPU_WAIT,
    parameter int MAX_DMA_RUN = DEF_MAX_DMA_RUN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rfsh_req,
    output logic            rfsh_gnt,
    input  logic [NREQ-1:0] dma_req,
    output logic [NREQ-1:0] dma_gnt,
    input  logic            cpu_as_n,
    output logic            cpu_gnt,
    output logic            cpu_dtack_n
);

    localparam int PW = $clog2(NREQ);
    localparam int SW = cnt_width(SLOT_LEN);
    localparam int WW = cnt_width(CPU_WAIT);
    localparam int RW = cnt_width(MAX_DMA_RUN);

    arb_state_e      state_q, state_d;
    logic [SW-1:0]   slot_cnt_q, slot_cnt_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [RW-1:0]   run_cnt_q, run_cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            rfsh_gnt_q, rfsh_gnt_d;
    logic [NREQ-1:0] dma_gnt_q, dma_gnt_d;
    logic            cpu_gnt_q, cpu_gnt_d;
    logic            cpu_dtack_n_q, cpu_dtack_n_d;

    logic [NREQ-1:0] pick_sel;
    logic            pick_any;
    logic [PW-1:0]   pick_idx;
    logic            run_full;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req (dma_req),
        .ptr (ptr_q),
        .sel (pick_sel),
        .any (pick_any)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_sel[i]) pick_idx = PW'(i);
        end
    end

    assign run_full = (run_cnt_q == RW'(MAX_DMA_RUN));

    always_comb begin
        state_d    = state_q;
        slot_cnt_d = slot_cnt_q;
        wait_cnt_d = wait_cnt_q;
        run_cnt_d  = run_cnt_q;
        ptr_d      = ptr_q;
        dma_gnt_d  = dma_gnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (rfsh_req) begin
                    state_d    = ST_RFSH;
                    slot_cnt_d = SW'(SLOT_LEN - 1);
                end else if (!cpu_as_n && (!pick_any || run_full)) begin
                    state_d    = ST_CPU_WAIT;
                    wait_cnt_d = WW'(CPU_WAIT - 1);
                    run_cnt_d  = '0;
                end else if (pick_any) begin
                    state_d    = ST_DMA;
                    slot_cnt_d = SW'(SLOT_LEN - 1);
                    ptr_d      = pick_idx;
                    dma_gnt_d  = pick_sel;
                    if (!cpu_as_n && !run_full) run_cnt_d = run_cnt_q + RW'(1);
                end
            end
            ST_RFSH, ST_DMA: begin
                // Slot length is fixed; request changes are ignored until it ends.
                if (slot_cnt_q == '0) state_d = ST_IDLE;
                else                  slot_cnt_d = slot_cnt_q - SW'(1);
            end
            ST_CPU_WAIT: begin
                if (cpu_as_n)              state_d = ST_IDLE;
                else if (wait_cnt_q == '0) state_d = ST_CPU_ACK;
                else                       wait_cnt_d = wait_cnt_q - WW'(1);
            end
            ST_CPU_ACK: begin
                if (cpu_as_n) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // The CPU releasing its strobe ends any starvation episode.
        if (cpu_as_n) run_cnt_d = '0;

        if (state_d != ST_DMA) dma_gnt_d = '0;
        rfsh_gnt_d    = (state_d == ST_RFSH);
        cpu_gnt_d     = (state_d == ST_CPU_WAIT) || (state_d == ST_CPU_ACK);
        cpu_dtack_n_d = (state_d != ST_CPU_ACK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            slot_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            run_cnt_q     <= '0;
            ptr_q         <= PW'(NREQ - 1);
            rfsh_gnt_q    <= 1'b0;
            dma_gnt_q     <= '0;
            cpu_gnt_q     <= 1'b0;
            cpu_dtack_n_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            slot_cnt_q    <= slot_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            run_cnt_q     <= run_cnt_d;
            ptr_q         <= ptr_d;
            rfsh_gnt_q    <= rfsh_gnt_d;
            dma_gnt_q     <= dma_gnt_d;
            cpu_gnt_q     <= cpu_gnt_d;
            cpu_dtack_n_q <= cpu_dtack_n_d;
        end
    end

    assign rfsh_gnt    = rfsh_gnt_q;
    assign dma_gnt     = dma_gnt_q;
    assign cpu_gnt     = cpu_gnt_q;
    assign cpu_dtack_n = cpu_dtack_n_q;

endmodule

// File: tb/tb_chip_bus_arbiter.sv
// Scoreboard bench: directed scenarios push expected grants, a negedge monitor
// measures each grant (vector, length, idle gap, DTACK timing) and compares.
module tb_chip_bus_arbiter;

    logic       clk;
    logic       reset;
    logic       rfsh_req;
    logic       rfsh_gnt;
    logic [3:0] dma_req;
    logic [3:0] dma_gnt;
    logic       cpu_as_n;
    logic       cpu_gnt;
    logic       cpu_dtack_n;

    chip_bus_arbiter #(
        .NREQ(4), .SLOT_LEN(2), .CPU_WAIT(2), .MAX_DMA_RUN(3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rfsh_req    (rfsh_req),
        .rfsh_gnt    (rfsh_gnt),
        .dma_req     (dma_req),
        .dma_gnt     (dma_gnt),
        .cpu_as_n    (cpu_as_n),
        .cpu_gnt     (cpu_gnt),
        .cpu_dtack_n (cpu_dtack_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // g = {rfsh, cpu, dma[3:0]}; gap/dt_at of -1 means "not checked" / "never".
    typedef struct {
        logic [5:0] g;
        int         len;
        int         gap;
        int         dt_at;
        int         dt_len;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks     = 0;
    int   errors     = 0;
    int   excl_viol  = 0;
    int   idle_cnt   = 0;
    int   hi_cnt     = 0;
    int   dt_first   = -1;
    int   dt_low     = 0;
    logic [5:0] prev_g = 6'b0;
    logic [5:0] g_now;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic push_exp(input logic [5:0] g, input int len, input int gap,
                            input int dt_at, input int dt_len);
        exp_t e;
        e.g = g; e.len = len; e.gap = gap; e.dt_at = dt_at; e.dt_len = dt_len;
        exp_q.push_back(e);
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; rfsh_req = 1'b0; dma_req = 4'b0; cpu_as_n = 1'b1;
        nclk(2);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        g_now = {rfsh_gnt, cpu_gnt, dma_gnt};
        if ($countones(g_now) > 1 || (!cpu_dtack_n && !cpu_gnt)) excl_viol++;
        if (g_now != 6'b0) begin
            if (prev_g == 6'b0) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_grant: got grant=%b, required none", g_now);
                    cur.len = -1; cur.g = g_now; cur.gap = -1;
                end else begin
                    cur = exp_q.pop_front();
                    check("grant_vector", int'(g_now), int'(cur.g));
                    if (cur.gap >= 0) check("idle_gap", idle_cnt, cur.gap);
                end
                hi_cnt = 0; dt_first = -1; dt_low = 0;
            end else if (g_now != prev_g) begin
                checks++; errors++;
                $display("FAIL grant_switch: got grant=%b after %b, required idle cycle between", g_now, prev_g);
            end
            if (!cpu_dtack_n) begin
                if (dt_first < 0) dt_first = hi_cnt;
                dt_low++;
            end
            hi_cnt++;
        end else begin
            if (prev_g != 6'b0) begin
                if (cur.len >= 0) begin
                    check("grant_len", hi_cnt, cur.len);
                    if (cur.g[4]) begin
                        check("dtack_delay", dt_first, cur.dt_at);
                        check("dtack_len", dt_low, cur.dt_len);
                    end
                end
                idle_cnt = 1;
            end else begin
                idle_cnt++;
            end
        end
        prev_g = g_now;
    end

    initial begin
        reset = 1'b1; rfsh_req = 1'b0; dma_req = 4'b0; cpu_as_n = 1'b1;
        nclk(3);
        check("rst_rfsh_gnt", int'(rfsh_gnt), 0);
        check("rst_dma_gnt", int'(dma_gnt), 0);
        check("rst_cpu_gnt", int'(cpu_gnt), 0);
        check("rst_dtack_n", int'(cpu_dtack_n), 1);
        reset = 1'b0;
        nclk(2);

        // CPU only: strobe low at edge 0, high at edge 5.
        push_exp(6'b010000, 5, -1, 2, 3);
        cpu_as_n = 1'b0; nclk(5);
        cpu_as_n = 1'b1; nclk(4);

        // All DMA channels held: ch0..ch3, ch0, 3-cycle period; drop mid-slot.
        do_reset();
        push_exp(6'b000001, 2, -1, -1, 0);
        push_exp(6'b000010, 2,  1, -1, 0);
        push_exp(6'b000100, 2,  1, -1, 0);
        push_exp(6'b001000, 2,  1, -1, 0);
        push_exp(6'b000001, 2,  1, -1, 0);
        dma_req = 4'b1111; nclk(13);
        dma_req = 4'b0000; nclk(5);

        // Refresh beats DMA channel 2 when both rise together.
        push_exp(6'b100000, 2, -1, -1, 0);
        push_exp(6'b000100, 2,  1, -1, 0);
        rfsh_req = 1'b1; dma_req = 4'b0100; nclk(1);
        rfsh_req = 1'b0; nclk(3);
        dma_req = 4'b0000; nclk(5);

        // Starvation limit: three DMA grants, then the waiting CPU, then ch3.
        do_reset();
        push_exp(6'b000001, 2, -1, -1, 0);
        push_exp(6'b000010, 2,  1, -1, 0);
        push_exp(6'b000100, 2,  1, -1, 0);
        push_exp(6'b010000, 4,  1,  2, 2);
        push_exp(6'b001000, 2,  1, -1, 0);
        dma_req = 4'b1111; cpu_as_n = 1'b0; nclk(13);
        cpu_as_n = 1'b1; nclk(2);
        dma_req = 4'b0000; nclk(5);

        // Aborted CPU cycle: no DTACK, grant lasts one cycle.
        push_exp(6'b010000, 1, -1, -1, 0);
        cpu_as_n = 1'b0; nclk(1);
        cpu_as_n = 1'b1; nclk(4);

        // Reset during ch1's slot, then ch0 is served first again.
        do_reset();
        push_exp(6'b000001, 2, -1, -1, 0);
        push_exp(6'b000010, 1,  1, -1, 0);
        push_exp(6'b000001, 2,  1, -1, 0);
        dma_req = 4'b1111; nclk(4);
        reset = 1'b1; nclk(1);
        check("midrst_rfsh_gnt", int'(rfsh_gnt), 0);
        check("midrst_dma_gnt", int'(dma_gnt), 0);
        check("midrst_cpu_gnt", int'(cpu_gnt), 0);
        check("midrst_dtack_n", int'(cpu_dtack_n), 1);
        reset = 1'b0; nclk(1);
        dma_req = 4'b0000; nclk(5);

        check("queue_empty", exp_q.size(), 0);
        check("exclusive_grants", excl_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chip_bus_arbiter.md
# chip_bus_arbiter

Synchronous arbiter that shares the chip-RAM bus between one 68000-style CPU port, a refresh requester and NREQ DMA channels. It sits between the CPU glue logic and the DMA/refresh sequencers, and replaces the discrete flip-flop handshake logic. It issues one-hot grants in fixed-length slots and generates the CPU's active-low DTACK.

## Interface
- NREQ, 4, number of DMA channels (2..8)
- SLOT_LEN, 2, cycles per DMA/refresh grant (≥1)
- CPU_WAIT, 2, wait cycles between CPU grant and DTACK assertion (≥1)
- MAX_DMA_RUN, 3, consecutive DMA grants allowed while the CPU waits (≥1)

- clk  in  1  the only clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- rfsh_req  in  1  refresh request, level, highest priority
- rfsh_gnt  out  1  refresh grant
- dma_req  in  NREQ  per-channel DMA request, level
- dma_gnt  out  NREQ  one-hot DMA grant
- cpu_as_n  in  1  CPU address strobe, active low
- cpu_gnt  out  1  CPU owns bus
- cpu_dtack_n  out  1  data acknowledge to CPU, active low

## Operation
- Reset values: rfsh_gnt=0, dma_gnt=0, cpu_gnt=0, cpu_dtack_n=1. State is IDLE, round-robin pointer is NREQ-1 (channel 0 is served first), and the starvation counter is 0.
- At most one of rfsh_gnt, cpu_gnt and any dma_gnt bit is high at any time.
- States and transitions:
  - IDLE: no grant. Arbitrates on registered decision every cycle, in this order:
    1. rfsh_req → RFSH.
    2. cpu_as_n low and (no dma_req or run counter == MAX_DMA_RUN) → CPU_WAIT.
    3. Any dma_req → DMA, with the channel chosen round-robin starting at pointer+1.
    4. Otherwise stay in IDLE.
  - RFSH / DMA: grant held for exactly SLOT_LEN cycles regardless of request changes, then → IDLE. A DMA grant updates the pointer to the granted channel.
  - CPU_WAIT: cpu_gnt=1. Counts CPU_WAIT cycles, then → CPU_ACK. If cpu_as_n is sampled high before that, the cycle is aborted → IDLE and DTACK is never asserted.
  - CPU_ACK: cpu_gnt=1, cpu_dtack_n=0 until cpu_as_n is sampled high → IDLE.
- Starvation counter:
  - Increments on each DMA grant issued while cpu_as_n is low.
  - Saturates at MAX_DMA_RUN.
  - Clears on a CPU grant or whenever cpu_as_n is sampled high.
  - Refresh grants do not change it.
- A request dropped before its grant is not served. A request dropped mid-slot does not shorten the slot.
- Reset mid-operation: all outputs reach reset values at the edge where reset is sampled. No partial slot resumes.

## Timing
- Request sampled at edge N in IDLE → grant high after edge N (same edge registers the decision), so grant-visible latency is 1 cycle from request setup.
- DMA/refresh slot: grant high for SLOT_LEN cycles, followed by exactly 1 IDLE turnaround cycle. Back-to-back period is SLOT_LEN+1 cycles.
- CPU: cpu_gnt rises at edge N. cpu_dtack_n falls at edge N+CPU_WAIT. When cpu_as_n is sampled high at edge K, cpu_dtack_n=1 and cpu_gnt=0 after edge K.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package chip_bus_pkg: state enum (IDLE, RFSH, DMA, CPU_WAIT, CPU_ACK) and default parameter constants.
- Sub-module rr_picker: combinational round-robin priority encoder.
  - Inputs: req[NREQ] and ptr[$clog2(NREQ)].
  - Outputs: one-hot sel[NREQ] and any.
- Counters are sized by $clog2 of their maximum plus 1.

## Test plan
(NREQ=4, SLOT_LEN=2, CPU_WAIT=2, MAX_DMA_RUN=3)
- CPU only: cpu_as_n low at edge 0 → cpu_gnt=1 after edge 0, cpu_dtack_n=0 after edge 2. cpu_as_n high at edge 5 → cpu_dtack_n=1 and cpu_gnt=0 after edge 5.
- dma_req=4'b1111 held after reset → grant order ch0, ch1, ch2, ch3, ch0. Each grant lasts 2 cycles with a 1-cycle gap, giving a 3-cycle period.
- rfsh_req and dma_req[2] rise together → rfsh_gnt for 2 cycles, idle gap, then dma_gnt=4'b0100.
- dma_req=4'b1111 plus cpu_as_n low → grants ch0, ch1, ch2, then CPU, then ch3.
- cpu_as_n low at edge 0, high at edge 1 → no cpu_dtack_n assertion, IDLE after edge 1.
- Reset asserted during ch1's slot → all grants 0 and cpu_dtack_n=1 next edge. After reset with dma_req=4'b1111, ch0 is granted first.
